// File: rtl/sine_sample_deserializer_if.sv
// Serial sample bus between sine ROM mapping stage (master) and deserializer (slave); no backpressure.
// Optional peak outputs exist only when DESER_PEAK_DETECT_EN is defined.
interface sine_sample_deserializer_if #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 16
);
  localparam int BW = $clog2(WIDTH + 1);

  logic             SI;
  logic             SI_en;
  logic             soc;
  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  logic             frame_err;
  logic [CNT_W-1:0] frame_cnt;
  logic [BW-1:0]    bit_cnt;
`ifdef DESER_PEAK_DETECT_EN
  logic [WIDTH-1:0] sample_min;
  logic [WIDTH-1:0] sample_max;
`endif

  modport master (
    output SI, SI_en, soc,
    input  sample, sample_valid, frame_err, frame_cnt, bit_cnt
`ifdef DESER_PEAK_DETECT_EN
    , input sample_min, sample_max
`endif
  );

  modport slave (
    input  SI, SI_en, soc,
    output sample, sample_valid, frame_err, frame_cnt, bit_cnt
`ifdef DESER_PEAK_DETECT_EN
    , output sample_min, sample_max
`endif
  );
endinterface

// File: rtl/sine_sample_deserializer.sv
// Rebuilds MSB-first serial frames into parallel samples; result/pulse one edge after soc, no backpressure.
// DESER_PEAK_DETECT_EN adds running unsigned min/max of accepted samples.
module sine_sample_deserializer #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  sine_sample_deserializer_if.slave bus
);
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
`ifdef DESER_PEAK_DETECT_EN
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bcnt_q   <= '0;
      sample_q <= '0;
      fcnt_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef DESER_PEAK_DETECT_EN
      min_q    <= '1;
      max_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bcnt_q   <= bcnt_d;
      sample_q <= sample_d;
      fcnt_q   <= fcnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
`ifdef DESER_PEAK_DETECT_EN
      min_q    <= min_d;
      max_q    <= max_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bcnt_d   = bcnt_q;
    sample_d = sample_q;
    fcnt_d   = fcnt_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
`ifdef DESER_PEAK_DETECT_EN
    min_d    = min_q;
    max_d    = max_q;
`endif
    if (bus.soc) begin
      if (state_q == FULL) begin
        sample_d = shreg_q;
        fcnt_d   = fcnt_q + CNT_W'(1);
        valid_d  = 1'b1;
`ifdef DESER_PEAK_DETECT_EN
        // Reset values (all-ones / zero) make the first good frame load both.
        if (shreg_q < min_q) min_d = shreg_q;
        if (shreg_q > max_q) max_d = shreg_q;
`endif
      end else begin
        err_d = 1'b1;
      end
      // A bit arriving with soc opens the next frame.
      if (bus.SI_en) begin
        shreg_d = {shreg_q[WIDTH-2:0], bus.SI};
        bcnt_d  = BW'(1);
        state_d = SHIFT;
      end else begin
        bcnt_d  = '0;
        state_d = IDLE;
      end
    end else if (bus.SI_en) begin
      case (state_q)
        IDLE, SHIFT: begin
          shreg_d = {shreg_q[WIDTH-2:0], bus.SI};
          bcnt_d  = bcnt_q + BW'(1);
          state_d = (bcnt_q == BW'(WIDTH - 1)) ? FULL : SHIFT;
        end
        default: state_d = OVER;
      endcase
    end
  end

  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.frame_err    = err_q;
  assign bus.frame_cnt    = fcnt_q;
  assign bus.bit_cnt      = bcnt_q;
`ifdef DESER_PEAK_DETECT_EN
  assign bus.sample_min   = min_q;
  assign bus.sample_max   = max_q;
`endif
endmodule

// File: tb/tb_sine_sample_deserializer.sv
// Directed bench for sine_sample_deserializer (WIDTH=12); peak checks only when DESER_PEAK_DETECT_EN is defined.
module tb_sine_sample_deserializer;
  localparam int WIDTH = 12;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sine_sample_deserializer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  sine_sample_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one clock edge, then sample 1 ns after it.
  task automatic step(input logic si, input logic en, input logic s);
    bus.SI    = si;
    bus.SI_en = en;
    bus.soc   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [15:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) step(val[i], 1'b1, 1'b0);
  endtask

  task automatic check_outs(input string tag, input logic [11:0] smp, input logic vld,
                            input logic err, input logic [15:0] cnt);
    check({tag, ".sample"},    bus.sample,       smp);
    check({tag, ".valid"},     bus.sample_valid, vld);
    check({tag, ".frame_err"}, bus.frame_err,    err);
    check({tag, ".frame_cnt"}, bus.frame_cnt,    cnt);
  endtask

  initial begin
    bus.SI = 1'b0; bus.SI_en = 1'b0; bus.soc = 1'b0;
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check_outs("reset", 12'h000, 1'b0, 1'b0, 16'd0);
    check("reset.bit_cnt", bus.bit_cnt, 0);
`ifdef DESER_PEAK_DETECT_EN
    check("reset.min", bus.sample_min, 12'hFFF);
    check("reset.max", bus.sample_max, 12'h000);
`endif
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // Good frame A5C, soc two cycles after the last bit
    shift_bits(16'h0A5C, 12);
    check("a5c.bit_cnt_full", bus.bit_cnt, 12);
    check("a5c.no_early_valid", bus.sample_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check_outs("a5c.close", 12'hA5C, 1'b1, 1'b0, 16'd1);
    check("a5c.bit_cnt_clr", bus.bit_cnt, 0);
    step(1'b0, 1'b0, 1'b0);
    check("a5c.valid_one_cycle", bus.sample_valid, 1'b0);

    // Short frame (7 bits)
    shift_bits(16'h0055, 7);
    check("short.bit_cnt", bus.bit_cnt, 7);
    step(1'b0, 1'b0, 1'b1);
    check_outs("short.close", 12'hA5C, 1'b0, 1'b1, 16'd1);
    check("short.bit_cnt_clr", bus.bit_cnt, 0);
    step(1'b0, 1'b0, 1'b0);
    check("short.err_one_cycle", bus.frame_err, 1'b0);

    // Overlong frame: FFF then two zeros; bit_cnt saturates
    shift_bits(16'h3FFC, 14);
    check("over.bit_cnt_sat", bus.bit_cnt, 12);
    step(1'b0, 1'b0, 1'b1);
    check_outs("over.close", 12'hA5C, 1'b0, 1'b1, 16'd1);
    shift_bits(16'h05A3, 12);
    step(1'b0, 1'b0, 1'b1);
    check_outs("after_over.close", 12'h5A3, 1'b1, 1'b0, 16'd2);

    // Held soc: following soc cycles see IDLE and each flags an error
    step(1'b0, 1'b0, 1'b1);
    check_outs("soc_hold1", 12'h5A3, 1'b0, 1'b1, 16'd2);
    step(1'b0, 1'b0, 1'b1);
    check_outs("soc_hold2", 12'h5A3, 1'b0, 1'b1, 16'd2);
    step(1'b0, 1'b0, 1'b0);

    // soc coincident with the first bit of 800
    shift_bits(16'h0001, 12);
    step(1'b1, 1'b1, 1'b1);
    check_outs("coinc.close001", 12'h001, 1'b1, 1'b0, 16'd3);
    check("coinc.bit_cnt_one", bus.bit_cnt, 1);
    shift_bits(16'h0000, 11);
    check("coinc.bit_cnt_full", bus.bit_cnt, 12);
    step(1'b0, 1'b0, 1'b1);
    check_outs("coinc.close800", 12'h800, 1'b1, 1'b0, 16'd4);
    step(1'b0, 1'b0, 1'b0);

    // Reset mid-frame discards the partial frame with no pulse
    shift_bits(16'h001F, 5);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check_outs("midrst", 12'h000, 1'b0, 1'b0, 16'd0);
    check("midrst.bit_cnt", bus.bit_cnt, 0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check_outs("midrst.after", 12'h000, 1'b0, 1'b0, 16'd0);
    shift_bits(16'h03C3, 12);
    step(1'b0, 1'b0, 1'b1);
    check_outs("midrst.3c3", 12'h3C3, 1'b1, 1'b0, 16'd1);
    step(1'b0, 1'b0, 1'b0);

`ifdef DESER_PEAK_DETECT_EN
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    shift_bits(16'h0400, 12);
    step(1'b0, 1'b0, 1'b1);
    check("peak.first_min", bus.sample_min, 12'h400);
    check("peak.first_max", bus.sample_max, 12'h400);
    shift_bits(16'h0C00, 12);
    step(1'b0, 1'b0, 1'b1);
    shift_bits(16'h0100, 12);
    step(1'b0, 1'b0, 1'b1);
    check("peak.min", bus.sample_min, 12'h100);
    check("peak.max", bus.sample_max, 12'hC00);
    check("peak.frame_cnt", bus.frame_cnt, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
